micro_sequencer: RTL and testbench
==================================

// Module: micro_sequencer
// PURPOSE
//  Parametrised microprogram sequencer for the ARM control unit; successor to the fixed 7-bit
//  encoder/incrementer/control-register loop. Drives the external combinational microstore address,
//  registers the returned microword, exposes Moore lines, selects next state (8 modes) and adds a
//  microsubroutine call/return stack, an MOC wait mode and dispatch-valid checking.
// PARAMETERS
//  ADDR_W      7   microstore address width
//  CW_W        32  microword width; layout {N[2:0], Inv, Moore[MOORE_W-1:0], CR[ADDR_W-1:0]}
//  MOORE_W     CW_W-4-ADDR_W (derived localparam, 21 at defaults)
//  STACK_DEPTH 4   call-stack entries (>=1)
//  RESET_ADDR  0   address taken in RESET mode, after reset and on faults
// PORTS
//  Clk        in   1        rising-edge clock
//  Reset_n    in   1        asynchronous, active-low reset
//  EncAddr    in   ADDR_W   dispatch address from instruction encoder
//  EncValid   in   1        1 = EncAddr decodes to a legal instruction
//  Cond       in   1        condition/status input (Sts)
//  MOC        in   1        memory operation complete
//  uAddr      out  ADDR_W   combinational address to microstore (selected next state)
//  uWord      in   CW_W     microstore data for uAddr (combinational ROM)
//  Moore      out  MOORE_W  control lines = CtrlQ Moore field
//  Err        out  1        sticky stack/dispatch fault flag
// BEHAVIOUR
//  - Registers: CtrlQ (CW_W), IncQ (ADDR_W), stack array + SP (0..STACK_DEPTH), Err.
//  - Reset (async, Reset_n=0): CtrlQ <= {3'd7, 0...}, IncQ <= 0, SP <= 0, Err <= 0; thus Moore=0,
//    uAddr=RESET_ADDR while in/after reset. Reset mid-call discards stack contents.
//  - Each posedge: CtrlQ <= uWord; IncQ <= uAddr+1 (mod 2^ADDR_W, wraps to 0); stack per mode.
//  - uAddr = f(CtrlQ.N), t = Cond ^ CtrlQ.Inv, m = MOC ^ CtrlQ.Inv:
//    0 ENC : EncValid ? EncAddr : RESET_ADDR, Err<=1 when !EncValid
//    1 INC : IncQ
//    2 JMP : CR
//    3 CJMP: t ? CR : IncQ
//    4 CALL: CR; push IncQ. SP==STACK_DEPTH: push dropped, jump still taken, Err<=1
//    5 RET : top-of-stack, pop. SP==0: RESET_ADDR, Err<=1, SP stays 0
//    6 WAIT: m ? IncQ : CR (CR normally = own address -> holds state until MOC)
//    7 RESET: RESET_ADDR
//  - One-cycle latency: a word fetched at uAddr appears on Moore after the next posedge.
//  - Err is cleared only by reset. Stack LIFO; CALL/RET never coincide (single mode per cycle).
//  - Cond, MOC, EncAddr, EncValid sampled combinationally in the cycle CtrlQ selects them.
// CONFIGURATION
//  UCODE_STACK_EN defined: stack as above.
//  Not defined: no stack storage; CALL behaves as JMP, RET behaves as ENC; stack faults never
//  raise Err (dispatch fault still does).
// STRUCTURE
//  Package useq_pkg: mode localparams (N_ENC..N_RESET), microword field offsets, CtrlQ reset word.
//  Sub-module useq_stack (push/pop/top/full/empty, SP), instantiated under UCODE_STACK_EN.
//  Top holds CtrlQ, IncQ, next-address mux, Err.
// TESTING
//  1 Reset_n low mid-run, uWord=32'hFFFF_FFFF -> Moore=0, uAddr=0 immediately; SP=0, Err=0.
//  2 Word at 0 = INC, at 1 = ENC; EncAddr=7'h07, EncValid=1 -> uAddr sequence 0,1,7'h07;
//    EncValid=0 -> uAddr=0, Err=1.
//  3 CJMP CR=7'h20, Inv=0: Cond=1 -> 7'h20; Cond=0 -> IncQ; Inv=1, Cond=0 -> 7'h20.
//  4 CALL CR=7'h30 at addr 5, then RET at 7'h30 -> uAddr 7'h30 then 6; nest 5 calls with
//    depth 4 -> fifth push dropped, Err=1; 5 RETs -> last gives RESET_ADDR.
//  5 WAIT at 7'h10 with CR=7'h10: MOC=0 for 3 cycles -> uAddr holds 7'h10; MOC=1 -> 7'h11.
//  6 INC at addr 7'h7F -> uAddr wraps to 0; rerun test 4 without UCODE_STACK_EN -> RET goes to
//    EncAddr, Err stays 0.

Source files
------------

// File: rtl/useq_pkg.sv
// rtl/useq_pkg.sv - shared constants for the microprogram sequencer
// Purpose : next-state mode codes, microword field positions and the control
//           register reset word used by micro_sequencer and its helpers.
// Ports   : none (package).
// Config  : UCODE_STACK_EN (consumed by micro_sequencer) enables the call stack.
package useq_pkg;

   localparam int N_W = 3;

   localparam logic [N_W-1:0] N_ENC   = 3'd0;
   localparam logic [N_W-1:0] N_INC   = 3'd1;
   localparam logic [N_W-1:0] N_JMP   = 3'd2;
   localparam logic [N_W-1:0] N_CJMP  = 3'd3;
   localparam logic [N_W-1:0] N_CALL  = 3'd4;
   localparam logic [N_W-1:0] N_RET   = 3'd5;
   localparam logic [N_W-1:0] N_WAIT  = 3'd6;
   localparam logic [N_W-1:0] N_RESET = 3'd7;

   // Microword layout, msb first: {N[2:0], Inv, Moore, CR}
   function automatic int n_lsb(input int cw_w);
      return cw_w - N_W;
   endfunction

   function automatic int inv_pos(input int cw_w);
      return cw_w - N_W - 1;
   endfunction

   function automatic int moore_msb(input int cw_w);
      return cw_w - N_W - 2;
   endfunction

   // Control register reset word: mode RESET, every other field zero
   localparam logic [N_W-1:0] CTRL_RESET_N = N_RESET;

endpackage

// File: rtl/micro_sequencer_if.sv
// rtl/micro_sequencer_if.sv - encoder, status, microstore and control-line bundle
// Purpose : groups the sequencer's non-clock signals.
// Ports   : EncAddr/EncValid (dispatch), Cond, MOC (status), uAddr/uWord
//           (microstore address/data), Moore (control lines), Err (fault flag).
//           master = environment side, slave = sequencer side.
interface micro_sequencer_if #(
   parameter int ADDR_W = 7,
   parameter int CW_W   = 32
);
   localparam int MOORE_W = CW_W - 4 - ADDR_W;

   logic [ADDR_W-1:0]  EncAddr;
   logic               EncValid;
   logic               Cond;
   logic               MOC;
   logic [ADDR_W-1:0]  uAddr;
   logic [CW_W-1:0]    uWord;
   logic [MOORE_W-1:0] Moore;
   logic               Err;

   modport master (
      output EncAddr, EncValid, Cond, MOC, uWord,
      input  uAddr, Moore, Err
   );

   modport slave (
      input  EncAddr, EncValid, Cond, MOC, uWord,
      output uAddr, Moore, Err
   );
endinterface

// File: rtl/useq_stack.sv
// rtl/useq_stack.sv - LIFO of microsubroutine return addresses
// Purpose : push/pop stack with stack pointer sp_q in 0..DEPTH.
// Ports   : clk, rst_n (async active-low), push, pop, push_data in;
//           top (entry at sp_q-1), full, empty out.
//           Push when full and pop when empty are ignored; the caller flags them.
module useq_stack #(
   parameter int ADDR_W = 7,
   parameter int DEPTH  = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              push,
   input  logic              pop,
   input  logic [ADDR_W-1:0] push_data,
   output logic [ADDR_W-1:0] top,
   output logic              full,
   output logic              empty
);
   localparam int SP_W  = $clog2(DEPTH + 1);
   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [SP_W-1:0]   sp_q, sp_d;
   logic [ADDR_W-1:0] mem_q [DEPTH];
   logic [IDX_W-1:0]  wr_idx, rd_idx;

   assign full   = (sp_q == SP_W'(DEPTH));
   assign empty  = (sp_q == '0);
   assign wr_idx = IDX_W'(sp_q);
   assign rd_idx = IDX_W'(sp_q - SP_W'(1));
   assign top    = mem_q[rd_idx];

   always_comb begin
      sp_d = sp_q;
      if (push && !full)
         sp_d = sp_q + SP_W'(1);
      else if (pop && !empty)
         sp_d = sp_q - SP_W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         sp_q <= '0;
      else
         sp_q <= sp_d;
   end

   // Entries are never reset: clearing sp_q alone discards them
   always_ff @(posedge clk) begin
      if (push && !full)
         mem_q[wr_idx] <= push_data;
   end
endmodule

// File: rtl/micro_sequencer.sv
// rtl/micro_sequencer.sv - microprogram sequencer top
// Purpose : registers the microword (ctrl_q) and the incremented address
//           (inc_q), selects the next microstore address from the 3-bit mode
//           field, and keeps a sticky fault flag.
// Ports   : Clk, Reset_n (async active-low); bus (micro_sequencer_if.slave).
// Config  : UCODE_STACK_EN defined -> CALL/RET use useq_stack; undefined ->
//           CALL acts as JMP, RET acts as ENC, and only dispatch faults set Err.
module micro_sequencer
   import useq_pkg::*;
#(
   parameter int                ADDR_W      = 7,
   parameter int                CW_W        = 32,
   parameter int                STACK_DEPTH = 4,
   parameter logic [ADDR_W-1:0] RESET_ADDR  = '0
) (
   input  logic            Clk,
   input  logic            Reset_n,
   micro_sequencer_if.slave bus
);
   localparam int MOORE_W = CW_W - 4 - ADDR_W;
   localparam logic [CW_W-1:0] CTRL_RESET = {CTRL_RESET_N, {(CW_W - N_W){1'b0}}};

   logic [CW_W-1:0]   ctrl_q, ctrl_d;
   logic [ADDR_W-1:0] inc_q, inc_d;
   logic              err_q, err_d;
   logic [ADDR_W-1:0] uaddr;

   logic [N_W-1:0]    mode;
   logic              inv, t, m;
   logic [ADDR_W-1:0] cr;

   assign mode = ctrl_q[n_lsb(CW_W) +: N_W];
   assign inv  = ctrl_q[inv_pos(CW_W)];
   assign cr   = ctrl_q[ADDR_W-1:0];
   assign t    = bus.Cond ^ inv;
   assign m    = bus.MOC ^ inv;

`ifdef UCODE_STACK_EN
   logic              push, pop, full, empty;
   logic [ADDR_W-1:0] top;

   useq_stack #(
      .ADDR_W (ADDR_W),
      .DEPTH  (STACK_DEPTH)
   ) u_stack (
      .clk       (Clk),
      .rst_n     (Reset_n),
      .push      (push),
      .pop       (pop),
      .push_data (inc_q),
      .top       (top),
      .full      (full),
      .empty     (empty)
   );
`endif

   always_comb begin
      uaddr = RESET_ADDR;
      err_d = err_q;
`ifdef UCODE_STACK_EN
      push  = 1'b0;
      pop   = 1'b0;
`endif
      case (mode)
         N_ENC: begin
            if (bus.EncValid) uaddr = bus.EncAddr;
            else              err_d = 1'b1;
         end
         N_INC:  uaddr = inc_q;
         N_JMP:  uaddr = cr;
         N_CJMP: uaddr = t ? cr : inc_q;
`ifdef UCODE_STACK_EN
         // Overflow still takes the jump; only the return address is lost
         N_CALL: begin
            uaddr = cr;
            push  = 1'b1;
            if (full) err_d = 1'b1;
         end
         N_RET: begin
            if (!empty) begin
               uaddr = top;
               pop   = 1'b1;
            end else begin
               err_d = 1'b1;
            end
         end
`else
         N_CALL: uaddr = cr;
         N_RET: begin
            if (bus.EncValid) uaddr = bus.EncAddr;
            else              err_d = 1'b1;
         end
`endif
         // CR normally points at the WAIT word itself, so !m parks here
         N_WAIT: uaddr = m ? inc_q : cr;
         default: uaddr = RESET_ADDR;
      endcase
   end

   assign ctrl_d    = bus.uWord;
   assign inc_d     = uaddr + ADDR_W'(1);
   assign bus.uAddr = uaddr;
   assign bus.Moore = ctrl_q[moore_msb(CW_W) -: MOORE_W];
   assign bus.Err   = err_q;

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         ctrl_q <= CTRL_RESET;
         inc_q  <= '0;
         err_q  <= 1'b0;
      end else begin
         ctrl_q <= ctrl_d;
         inc_q  <= inc_d;
         err_q  <= err_d;
      end
   end
endmodule

// File: tb/tb_micro_sequencer.sv
// tb/tb_micro_sequencer.sv - directed self-checking bench for micro_sequencer
module tb_micro_sequencer;
   import useq_pkg::*;

   logic Clk = 1'b0;
   logic Reset_n = 1'b0;
   int checks = 0;
   int errors = 0;
   logic [31:0] rom [0:127];

   micro_sequencer_if bus ();

   micro_sequencer dut (
      .Clk     (Clk),
      .Reset_n (Reset_n),
      .bus     (bus)
   );

   always #5 Clk = ~Clk;

   assign bus.uWord = rom[bus.uAddr];

   function automatic logic [31:0] mw(input logic [2:0] n, input logic inv,
                                      input logic [6:0] tag, input logic [6:0] cr);
      return {n, inv, 14'h0, tag, cr};
   endfunction

   task automatic clear_rom;
      for (int i = 0; i < 128; i++) begin
         logic [6:0] a;
         a = i[6:0];
         rom[i] = mw(N_RESET, 1'b0, a, 7'h00);
      end
   endtask

   task automatic step;
      @(posedge Clk);
      #1;
   endtask

   task automatic reset_pulse;
      Reset_n = 1'b0;
      @(posedge Clk);
      #1;
      Reset_n = 1'b1;
   endtask

   task automatic test_reset;
      for (int i = 0; i < 128; i++) rom[i] = 32'hFFFF_FFFF;
      bus.EncAddr = 7'h00; bus.EncValid = 1'b1; bus.Cond = 1'b0; bus.MOC = 1'b0;
      reset_pulse();
      step(); step();
      checks++; if (bus.Moore !== 21'h1FFFFF) begin errors++; $display("FAIL reset_prerun_moore got %h want %h", bus.Moore, 21'h1FFFFF); end
      checks++; if (bus.uAddr !== 7'h00) begin errors++; $display("FAIL reset_prerun_uaddr got %h want %h", bus.uAddr, 7'h00); end
      #3;
      Reset_n = 1'b0;
      #1;
      checks++; if (bus.Moore !== 21'h0) begin errors++; $display("FAIL reset_async_moore got %h want %h", bus.Moore, 21'h0); end
      checks++; if (bus.uAddr !== 7'h00) begin errors++; $display("FAIL reset_async_uaddr got %h want %h", bus.uAddr, 7'h00); end
      checks++; if (bus.Err !== 1'b0) begin errors++; $display("FAIL reset_async_err got %b want %b", bus.Err, 1'b0); end
      step();
      checks++; if (bus.Moore !== 21'h0) begin errors++; $display("FAIL reset_held_moore got %h want %h", bus.Moore, 21'h0); end
      Reset_n = 1'b1;
   endtask

   task automatic test_enc;
      logic [6:0]  exp_ua [4] = '{7'h01, 7'h07, 7'h00, 7'h01};
      logic [20:0] exp_mo [4] = '{21'h00, 21'h01, 21'h07, 21'h00};
      clear_rom();
      rom[0] = mw(N_INC, 1'b0, 7'h00, 7'h00);
      rom[1] = mw(N_ENC, 1'b0, 7'h01, 7'h00);
      bus.EncAddr = 7'h07; bus.EncValid = 1'b1;
      reset_pulse();
      checks++; if (bus.uAddr !== 7'h00) begin errors++; $display("FAIL enc_start_uaddr got %h want %h", bus.uAddr, 7'h00); end
      checks++; if (bus.Err !== 1'b0) begin errors++; $display("FAIL enc_start_err got %b want %b", bus.Err, 1'b0); end
      for (int i = 0; i < 4; i++) begin
         step();
         checks++; if (bus.uAddr !== exp_ua[i]) begin errors++; $display("FAIL enc_seq_uaddr[%0d] got %h want %h", i, bus.uAddr, exp_ua[i]); end
         checks++; if (bus.Moore !== exp_mo[i]) begin errors++; $display("FAIL enc_seq_moore[%0d] got %h want %h", i, bus.Moore, exp_mo[i]); end
      end
      bus.EncValid = 1'b0;
      step();
      checks++; if (bus.uAddr !== 7'h00) begin errors++; $display("FAIL enc_invalid_uaddr got %h want %h", bus.uAddr, 7'h00); end
      checks++; if (bus.Err !== 1'b0) begin errors++; $display("FAIL enc_invalid_err_early got %b want %b", bus.Err, 1'b0); end
      step();
      checks++; if (bus.Err !== 1'b1) begin errors++; $display("FAIL enc_invalid_err got %b want %b", bus.Err, 1'b1); end
      bus.EncValid = 1'b1;
      step();
      checks++; if (bus.Err !== 1'b1) begin errors++; $display("FAIL enc_err_sticky got %b want %b", bus.Err, 1'b1); end
   endtask

   task automatic test_cjmp;
      clear_rom();
      rom[0] = mw(N_CJMP, 1'b0, 7'h00, 7'h20);
      bus.Cond = 1'b1;
      reset_pulse();
      checks++; if (bus.Err !== 1'b0) begin errors++; $display("FAIL cjmp_reset_err got %b want %b", bus.Err, 1'b0); end
      step();
      checks++; if (bus.uAddr !== 7'h20) begin errors++; $display("FAIL cjmp_taken got %h want %h", bus.uAddr, 7'h20); end
      bus.Cond = 1'b0;
      #1;
      checks++; if (bus.uAddr !== 7'h01) begin errors++; $display("FAIL cjmp_fall got %h want %h", bus.uAddr, 7'h01); end
      rom[0] = mw(N_CJMP, 1'b1, 7'h00, 7'h20);
      reset_pulse();
      step();
      checks++; if (bus.uAddr !== 7'h20) begin errors++; $display("FAIL cjmp_inv_taken got %h want %h", bus.uAddr, 7'h20); end
      bus.Cond = 1'b1;
      #1;
      checks++; if (bus.uAddr !== 7'h01) begin errors++; $display("FAIL cjmp_inv_fall got %h want %h", bus.uAddr, 7'h01); end
      bus.Cond = 1'b0;
   endtask

   task automatic load_call_rom;
      clear_rom();
      rom[7'h00] = mw(N_JMP,  1'b0, 7'h00, 7'h05);
      rom[7'h05] = mw(N_CALL, 1'b0, 7'h05, 7'h30);
      rom[7'h30] = mw(N_RET,  1'b0, 7'h30, 7'h00);
      rom[7'h06] = mw(N_JMP,  1'b0, 7'h06, 7'h40);
      rom[7'h7A] = mw(N_JMP,  1'b0, 7'h7A, 7'h40);
      rom[7'h40] = mw(N_CALL, 1'b0, 7'h40, 7'h48);
      rom[7'h48] = mw(N_CALL, 1'b0, 7'h48, 7'h50);
      rom[7'h50] = mw(N_CALL, 1'b0, 7'h50, 7'h58);
      rom[7'h58] = mw(N_CALL, 1'b0, 7'h58, 7'h60);
      rom[7'h60] = mw(N_CALL, 1'b0, 7'h60, 7'h68);
      rom[7'h68] = mw(N_RET,  1'b0, 7'h68, 7'h00);
      rom[7'h59] = mw(N_RET,  1'b0, 7'h59, 7'h00);
      rom[7'h51] = mw(N_RET,  1'b0, 7'h51, 7'h00);
      rom[7'h49] = mw(N_RET,  1'b0, 7'h49, 7'h00);
      rom[7'h41] = mw(N_RET,  1'b0, 7'h41, 7'h00);
      bus.EncAddr = 7'h7A; bus.EncValid = 1'b1;
   endtask

   task automatic test_call_ret;
`ifdef UCODE_STACK_EN
      logic [6:0] exp_ua [$] = '{7'h05, 7'h30, 7'h06, 7'h40, 7'h48, 7'h50, 7'h58,
                                 7'h60, 7'h68, 7'h59, 7'h51, 7'h49, 7'h41, 7'h00};
      logic       exp_er [$] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1};
`else
      logic [6:0] exp_ua [$] = '{7'h05, 7'h30, 7'h7A, 7'h40, 7'h48, 7'h50, 7'h58,
                                 7'h60, 7'h68, 7'h7A};
      logic       exp_er [$] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
`endif
      logic [6:0] prev;
      load_call_rom();
      reset_pulse();
      prev = 7'h00;
      for (int i = 0; i < exp_ua.size(); i++) begin
         step();
         checks++; if (bus.uAddr !== exp_ua[i]) begin errors++; $display("FAIL call_uaddr[%0d] got %h want %h", i, bus.uAddr, exp_ua[i]); end
         checks++; if (bus.Err !== exp_er[i]) begin errors++; $display("FAIL call_err[%0d] got %b want %b", i, bus.Err, exp_er[i]); end
         checks++; if (bus.Moore !== {14'h0, prev}) begin errors++; $display("FAIL call_moore[%0d] got %h want %h", i, bus.Moore, {14'h0, prev}); end
         prev = exp_ua[i];
      end
   endtask

   task automatic test_reset_mid_call;
`ifdef UCODE_STACK_EN
      logic [6:0] exp_ret = 7'h00;
      logic       exp_err = 1'b1;
`else
      logic [6:0] exp_ret = 7'h7A;
      logic       exp_err = 1'b0;
`endif
      load_call_rom();
      reset_pulse();
      step(); step();
      checks++; if (bus.uAddr !== 7'h30) begin errors++; $display("FAIL midcall_in_sub got %h want %h", bus.uAddr, 7'h30); end
      Reset_n = 1'b0;
      rom[0] = mw(N_RET, 1'b0, 7'h00, 7'h00);
      #1;
      checks++; if (bus.uAddr !== 7'h00) begin errors++; $display("FAIL midcall_reset_uaddr got %h want %h", bus.uAddr, 7'h00); end
      @(posedge Clk);
      #1;
      Reset_n = 1'b1;
      step();
      checks++; if (bus.uAddr !== exp_ret) begin errors++; $display("FAIL midcall_ret_uaddr got %h want %h", bus.uAddr, exp_ret); end
      step();
      checks++; if (bus.Err !== exp_err) begin errors++; $display("FAIL midcall_ret_err got %b want %b", bus.Err, exp_err); end
   endtask

   task automatic test_wait;
      clear_rom();
      rom[7'h00] = mw(N_JMP,  1'b0, 7'h00, 7'h10);
      rom[7'h10] = mw(N_WAIT, 1'b0, 7'h10, 7'h10);
      bus.MOC = 1'b0;
      reset_pulse();
      step();
      checks++; if (bus.uAddr !== 7'h10) begin errors++; $display("FAIL wait_enter got %h want %h", bus.uAddr, 7'h10); end
      for (int i = 0; i < 3; i++) begin
         step();
         checks++; if (bus.uAddr !== 7'h10) begin errors++; $display("FAIL wait_hold[%0d] got %h want %h", i, bus.uAddr, 7'h10); end
      end
      bus.MOC = 1'b1;
      #1;
      checks++; if (bus.uAddr !== 7'h11) begin errors++; $display("FAIL wait_release got %h want %h", bus.uAddr, 7'h11); end
      step();
      checks++; if (bus.Moore !== 21'h11) begin errors++; $display("FAIL wait_next_moore got %h want %h", bus.Moore, 21'h11); end
      bus.MOC = 1'b0;
   endtask

   task automatic test_wrap;
      clear_rom();
      rom[7'h00] = mw(N_JMP, 1'b0, 7'h00, 7'h7F);
      rom[7'h7F] = mw(N_INC, 1'b0, 7'h7F, 7'h00);
      reset_pulse();
      step();
      checks++; if (bus.uAddr !== 7'h7F) begin errors++; $display("FAIL wrap_top got %h want %h", bus.uAddr, 7'h7F); end
      step();
      checks++; if (bus.uAddr !== 7'h00) begin errors++; $display("FAIL wrap_zero got %h want %h", bus.uAddr, 7'h00); end
      checks++; if (bus.Moore !== 21'h7F) begin errors++; $display("FAIL wrap_moore got %h want %h", bus.Moore, 21'h7F); end
   endtask

   initial begin
      test_reset();
      test_enc();
      test_cjmp();
      test_call_ret();
      test_reset_mid_call();
      test_wait();
      test_wrap();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
